// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt front-end.
//   exc_state_t  : request FSM states
//   EXC_*        : 5-bit ExcCode values placed in cause[6:2]
//   CAUSE_IP_LSB : bit position of the pending-IRQ field inside cause
//   pack_cause   : merges an ExcCode with an already-positioned IP field
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } exc_state_t;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int CAUSE_IP_LSB = 8;

    // ip_field must already be shifted to CAUSE_IP_LSB; the ExcCode lands in [6:2].
    function automatic logic [31:0] pack_cause(input logic [4:0] code,
                                               input logic [31:0] ip_field);
        return ip_field | {25'd0, code, 2'b00};
    endfunction

endpackage

// File: rtl/exception_unit_irq_sync.sv
// Per-line interrupt conditioner: two-flop synchronizer followed by a
// registered rising-edge detector.
//   clock : system clock
//   reset : asynchronous, active-low
//   din   : raw asynchronous interrupt level
//   rise  : one-cycle pulse, high two cycles after din is first sampled high
module irq_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;
    logic rise_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
            rise_reg <= sync_reg & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt front-end for the multicycle MIPS core.
// Collects overflow / reserved-opcode faults and external IRQs, raises
// exc_req to the control unit, commits EPC/Cause on exc_ack and tracks
// the handler (EXL) state until eret.
//   clock, reset          : clock, asynchronous active-low reset
//   irq                   : external interrupt levels (rising edge requests)
//   irq_mask_we/_wdata    : mask register write port (1 = enabled)
//   ovf_evt, ri_evt       : sync fault pulses, fault_pc valid with them
//   boundary, resume_pc   : interrupt-safe point and the PC to resume at
//   exc_ack, eret         : request taken / handler return
//   exc_req               : request to control unit
//   vector                : handler entry address (constant)
//   epc, cause            : committed return address and cause word
//   in_handler            : EXL flag
//   irq_pending           : latched pending IRQs
//   err_sticky            : fault seen while a handler was running
module exception_unit
    import exc_pkg::*;
#(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             irq_mask_we,
    input  logic [N_IRQ-1:0] irq_mask_wdata,
    input  logic             ovf_evt,
    input  logic             ri_evt,
    input  logic [31:0]      fault_pc,
    input  logic             boundary,
    input  logic [31:0]      resume_pc,
    input  logic             exc_ack,
    input  logic             eret,
    output logic             exc_req,
    output logic [31:0]      vector,
    output logic [31:0]      epc,
    output logic [31:0]      cause,
    output logic             in_handler,
    output logic [N_IRQ-1:0] irq_pending,
    output logic             err_sticky
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    exc_state_t       state_reg, state_next;
    logic [4:0]       code_reg, code_next;
    logic [31:0]      pc_reg, pc_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             is_irq_reg, is_irq_next;
    logic [31:0]      epc_reg, epc_next;
    logic [31:0]      cause_reg, cause_next;
    logic [N_IRQ-1:0] pending_reg, pending_next;
    logic [N_IRQ-1:0] mask_reg, mask_next;
    logic             err_reg, err_next;

    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] serviceable;
    logic [N_IRQ-1:0] clr_vec;
    logic [IDX_W-1:0] sel_idx;
    logic             sync_evt;
    logic [4:0]       sync_code;

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_irq
            irq_sync u_sync (
                .clock (clock),
                .reset (reset),
                .din   (irq[gi]),
                .rise  (irq_rise[gi])
            );
        end
    endgenerate

    // Masked lines still latch pending; the mask only qualifies the request.
    assign serviceable = pending_reg & mask_reg;
    assign sync_evt    = ri_evt | ovf_evt;
    // RI outranks OV when both fire together.
    assign sync_code   = ri_evt ? EXC_RI : EXC_OV;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        sel_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (serviceable[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            code_reg    <= '0;
            pc_reg      <= '0;
            idx_reg     <= '0;
            is_irq_reg  <= 1'b0;
            epc_reg     <= '0;
            cause_reg   <= '0;
            pending_reg <= '0;
            mask_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            pc_reg      <= pc_next;
            idx_reg     <= idx_next;
            is_irq_reg  <= is_irq_next;
            epc_reg     <= epc_next;
            cause_reg   <= cause_next;
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        pc_next     = pc_reg;
        idx_next    = idx_reg;
        is_irq_next = is_irq_reg;
        epc_next    = epc_reg;
        cause_next  = cause_reg;
        err_next    = err_reg;
        clr_vec     = '0;

        case (state_reg)
            IDLE: begin
                // A fault always beats an IRQ at the same boundary; the IRQ stays pending.
                if (sync_evt) begin
                    code_next   = sync_code;
                    pc_next     = fault_pc;
                    is_irq_next = 1'b0;
                    state_next  = REQ;
                end else if (boundary && (|serviceable)) begin
                    code_next   = EXC_INT;
                    pc_next     = resume_pc;
                    idx_next    = sel_idx;
                    is_irq_next = 1'b1;
                    state_next  = REQ;
                end
            end

            REQ: begin
                if (exc_ack) begin
                    epc_next   = pc_reg;
                    // IP reflects pending as seen just before the serviced bit is cleared.
                    cause_next = pack_cause(code_reg, 32'(pending_reg) << CAUSE_IP_LSB);
                    for (int i = 0; i < N_IRQ; i++) begin
                        clr_vec[i] = is_irq_reg && (idx_reg == IDX_W'(i));
                    end
                    state_next = HANDLER;
                end else if (sync_evt && is_irq_reg) begin
                    // A fault pre-empts an interrupt request not yet taken;
                    // the interrupt remains pending for later.
                    code_next   = sync_code;
                    pc_next     = fault_pc;
                    is_irq_next = 1'b0;
                end
            end

            HANDLER: begin
                if (sync_evt) begin
                    err_next = 1'b1;
                end
                if (eret) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A new edge on the bit being cleared wins, so no event is lost.
    assign pending_next = (pending_reg & ~clr_vec) | irq_rise;
    assign mask_next    = irq_mask_we ? irq_mask_wdata : mask_reg;

    assign exc_req     = (state_reg == REQ);
    assign in_handler  = (state_reg == HANDLER);
    assign vector      = EXC_VECTOR;
    assign epc         = epc_reg;
    assign cause       = cause_reg;
    assign irq_pending = pending_reg;
    assign err_sticky  = err_reg;

endmodule

// File: tb/tb_exception_unit.sv
module tb_exception_unit;

    logic        clock;
    logic        reset;
    logic [3:0]  irq;
    logic        irq_mask_we;
    logic [3:0]  irq_mask_wdata;
    logic        ovf_evt;
    logic        ri_evt;
    logic [31:0] fault_pc;
    logic        boundary;
    logic [31:0] resume_pc;
    logic        exc_ack;
    logic        eret;
    logic        exc_req;
    logic [31:0] vector;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        in_handler;
    logic [3:0]  irq_pending;
    logic        err_sticky;

    int total;
    int bad;

    exception_unit #(
        .N_IRQ      (4),
        .EXC_VECTOR (32'h0000_0100)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .irq            (irq),
        .irq_mask_we    (irq_mask_we),
        .irq_mask_wdata (irq_mask_wdata),
        .ovf_evt        (ovf_evt),
        .ri_evt         (ri_evt),
        .fault_pc       (fault_pc),
        .boundary       (boundary),
        .resume_pc      (resume_pc),
        .exc_ack        (exc_ack),
        .eret           (eret),
        .exc_req        (exc_req),
        .vector         (vector),
        .epc            (epc),
        .cause          (cause),
        .in_handler     (in_handler),
        .irq_pending    (irq_pending),
        .err_sticky     (err_sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b0;
        irq            = 4'b0000;
        irq_mask_we    = 1'b0;
        irq_mask_wdata = 4'b0000;
        ovf_evt        = 1'b0;
        ri_evt         = 1'b0;
        fault_pc       = 32'h0;
        boundary       = 1'b0;
        resume_pc      = 32'h0;
        exc_ack        = 1'b0;
        eret           = 1'b0;

        // Reset state
        #3;
        chk("rst_exc_req",    32'(exc_req),     32'h0);
        chk("rst_epc",        epc,              32'h0);
        chk("rst_cause",      cause,            32'h0);
        chk("rst_in_handler", 32'(in_handler),  32'h0);
        chk("rst_pending",    32'(irq_pending), 32'h0);
        chk("rst_err",        32'(err_sticky),  32'h0);
        chk("vector",         vector,           32'h0000_0100);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 1: overflow
        ovf_evt  = 1'b1;
        fault_pc = 32'h40;
        tick();
        ovf_evt = 1'b0;
        chk("t1_req",        32'(exc_req),    32'h1);
        chk("t1_not_in_h",   32'(in_handler), 32'h0);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("t1_req_drop",   32'(exc_req),    32'h0);
        chk("t1_epc",        epc,             32'h40);
        chk("t1_cause",      cause,           32'h30);
        chk("t1_in_handler", 32'(in_handler), 32'h1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("t1_eret_exl",   32'(in_handler), 32'h0);

        // 2: RI and OV together -> RI
        ri_evt   = 1'b1;
        ovf_evt  = 1'b1;
        fault_pc = 32'h80;
        tick();
        ri_evt  = 1'b0;
        ovf_evt = 1'b0;
        chk("t2_req",   32'(exc_req), 32'h1);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("t2_epc",   epc,   32'h80);
        chk("t2_cause", cause, 32'h28);
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // 3: masked-in IRQ2 at a boundary
        irq_mask_we    = 1'b1;
        irq_mask_wdata = 4'b0101;
        tick();
        irq_mask_we = 1'b0;
        irq[2]      = 1'b1;
        tick();                                  // edge t samples the rise
        tick();                                  // t+1
        tick();                                  // t+2
        chk("t3_pend_early", 32'(irq_pending), 32'h0);
        tick();                                  // t+3
        chk("t3_pend",       32'(irq_pending), 32'h4);
        chk("t3_no_req",     32'(exc_req),     32'h0);
        boundary  = 1'b1;
        resume_pc = 32'h200;
        tick();                                  // t+4
        boundary = 1'b0;
        chk("t3_req",        32'(exc_req),     32'h1);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("t3_epc",        epc,              32'h200);
        chk("t3_cause",      cause,            32'h400);
        chk("t3_pend_clr",   32'(irq_pending), 32'h0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("t3_idle_req",   32'(exc_req),     32'h0);

        // 4: masked IRQ1 latches but does not request until mask is written
        irq_mask_we    = 1'b1;
        irq_mask_wdata = 4'b0000;
        tick();
        irq_mask_we = 1'b0;
        irq[1]      = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("t4_pend",        32'(irq_pending), 32'h2);
        boundary  = 1'b1;
        resume_pc = 32'h300;
        tick();
        chk("t4_masked",      32'(exc_req),     32'h0);
        irq_mask_we    = 1'b1;
        irq_mask_wdata = 4'b0010;
        tick();
        irq_mask_we = 1'b0;
        chk("t4_mask_lag",    32'(exc_req),     32'h0);
        tick();
        boundary = 1'b0;
        chk("t4_req",         32'(exc_req),     32'h1);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("t4_epc",         epc,              32'h300);
        chk("t4_cause",       cause,            32'h200);
        chk("t4_pend_clr",    32'(irq_pending), 32'h0);

        // 5: fault and IRQ0 while in the handler
        ovf_evt  = 1'b1;
        fault_pc = 32'h44;
        tick();
        ovf_evt = 1'b0;
        chk("t5_err",         32'(err_sticky),  32'h1);
        chk("t5_no_req",      32'(exc_req),     32'h0);
        chk("t5_epc_kept",    epc,              32'h300);
        irq_mask_we    = 1'b1;
        irq_mask_wdata = 4'b0011;
        irq[0]         = 1'b1;
        tick();                                  // t
        irq_mask_we = 1'b0;
        tick();
        tick();
        tick();                                  // t+3
        chk("t5_pend",        32'(irq_pending), 32'h1);
        chk("t5_h_no_req",    32'(exc_req),     32'h0);
        chk("t5_in_h",        32'(in_handler),  32'h1);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("t5_eret",        32'(in_handler),  32'h0);
        boundary  = 1'b1;
        resume_pc = 32'h500;
        tick();
        boundary = 1'b0;
        chk("t5_req",         32'(exc_req),     32'h1);
        chk("t5_err_keep",    32'(err_sticky),  32'h1);

        // 6: async reset while in REQ
        reset = 1'b0;
        #2;
        chk("t6_req",     32'(exc_req),     32'h0);
        chk("t6_epc",     epc,              32'h0);
        chk("t6_cause",   cause,            32'h0);
        chk("t6_pend",    32'(irq_pending), 32'h0);
        chk("t6_err",     32'(err_sticky),  32'h0);
        irq = 4'b0000;
        tick();
        tick();
        reset = 1'b1;
        exc_ack = 1'b1;                          // ack outside REQ is ignored
        tick();
        exc_ack = 1'b0;
        chk("t6_ack_idle", 32'(in_handler), 32'h0);
        ri_evt   = 1'b1;
        fault_pc = 32'h60;
        tick();
        ri_evt = 1'b0;
        chk("t6_req_again", 32'(exc_req),   32'h1);
        exc_ack = 1'b1;
        eret    = 1'b1;                          // eret with ack in REQ is ignored
        tick();
        exc_ack = 1'b0;
        eret    = 1'b0;
        chk("t6_epc_new",   epc,            32'h60);
        chk("t6_in_h",      32'(in_handler), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
